// File: rtl/edl_pio_pkg.sv
// Shared register map and encodings for the edge-detecting input PIO.
package edl_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned EDGE_NONE    = 0;
    localparam int unsigned EDGE_RISING  = 1;
    localparam int unsigned EDGE_FALLING = 2;
    localparam int unsigned EDGE_ANY     = 3;

    localparam int unsigned IRQ_LEVEL = 0;
    localparam int unsigned IRQ_EDGE  = 1;

    function automatic logic [31:0] edge_select(input logic [31:0] rise,
                                                input logic [31:0] fall,
                                                input int unsigned etype);
        logic [31:0] ev;
        ev = '0;
        case (etype)
            EDGE_RISING:  ev = rise;
            EDGE_FALLING: ev = fall;
            EDGE_ANY:     ev = rise | fall;
            default:      ev = '0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/edl_pio_sync.sv
// Multi-bit flop-chain synchroniser; zero stages is a wire-through for already-synchronous inputs.
module edl_pio_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (STAGES == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_chain
        logic [WIDTH-1:0] chain_q [STAGES];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
            end else begin
                chain_q[0] <= din;
                for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
            end
        end

        assign dout = chain_q[STAGES-1];
    end

endmodule

// File: rtl/edl_pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture and level/edge interrupt.
module edl_pio_in_edge
    import edl_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISING,
    parameter int unsigned IRQ_TYPE    = IRQ_LEVEL,
    parameter bit          BIT_CLEAR   = 1'b1,
    parameter logic [31:0] RESET_MASK  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq,
    output logic [31:0]           readdata
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
        $error("edl_pio_in_edge: DATA_WIDTH must be 1..32");
    end
    if (SYNC_STAGES > 3) begin : g_bad_sync
        $error("edl_pio_in_edge: SYNC_STAGES must be 0..3");
    end
    if (IRQ_TYPE == IRQ_EDGE && EDGE_TYPE == EDGE_NONE) begin : g_bad_irq
        $error("edl_pio_in_edge: edge IRQ requires an edge source");
    end

    logic [DATA_WIDTH-1:0] data_s;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] event_v;
    logic [DATA_WIDTH-1:0] clr;
    logic [31:0]           ev_all;
    logic [31:0]           readdata_d;
    logic [1:0]            arm_cnt_q;
    logic                  armed_q;
    logic                  wr_en;

    edl_pio_sync #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .dout    (data_s)
    );

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        ev_all  = edge_select(32'(data_s & ~prev_q), 32'(~data_s & prev_q), EDGE_TYPE);
        // Until the chain and prev have flushed post-reset, any apparent edge is fake.
        event_v = armed_q ? ev_all[DATA_WIDTH-1:0] : '0;

        clr = '0;
        if (wr_en && address == ADDR_EDGE) begin
            clr = BIT_CLEAR ? writedata[DATA_WIDTH-1:0] : '1;
        end
        // OR the event in after clearing so a same-cycle edge is never lost.
        cap_d = (cap_q & ~clr) | event_v;

        readdata_d = '0;
        unique case (address)
            ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = data_s;
            ADDR_MASK: readdata_d[DATA_WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata_d[DATA_WIDTH-1:0] = cap_q;
            default:   readdata_d = '0;
        endcase

        if (IRQ_TYPE == IRQ_EDGE) irq = |(cap_q & mask_q);
        else                      irq = |(data_s & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            arm_cnt_q <= arm_cnt_q + 2'd1;
            if (arm_cnt_q == 2'(SYNC_STAGES)) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q   <= '0;
            cap_q    <= '0;
            mask_q   <= RESET_MASK[DATA_WIDTH-1:0];
            readdata <= '0;
        end else begin
            prev_q   <= data_s;
            cap_q    <= cap_d;
            readdata <= readdata_d;
            if (wr_en && address == ADDR_MASK) mask_q <= writedata[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_edl_pio_in_edge.sv
// Directed bench: three 8-bit instances (rising/edge-irq, rising/level-irq, falling/clear-all).
module tb_edl_pio_in_edge;
    import edl_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic [2:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_r, in_l, in_f;
    logic        irq_r, irq_l, irq_f;
    logic [31:0] rdata_r, rdata_l, rdata_f;
    logic [31:0] val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edl_pio_in_edge #(
        .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING), .IRQ_TYPE(IRQ_EDGE),
        .BIT_CLEAR(1'b1), .RESET_MASK(32'h0)
    ) u_dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .in_port(in_r), .irq(irq_r),
        .readdata(rdata_r)
    );

    edl_pio_in_edge #(
        .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING), .IRQ_TYPE(IRQ_LEVEL),
        .BIT_CLEAR(1'b1), .RESET_MASK(32'h0)
    ) u_dut_l (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .in_port(in_l), .irq(irq_l),
        .readdata(rdata_l)
    );

    edl_pio_in_edge #(
        .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_FALLING), .IRQ_TYPE(IRQ_EDGE),
        .BIT_CLEAR(1'b0), .RESET_MASK(32'h0)
    ) u_dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .in_port(in_f), .irq(irq_f),
        .readdata(rdata_f)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int which, input logic [1:0] addr, input logic [31:0] data);
        cs        = 3'b000;
        cs[which] = 1'b1;
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
        tick(1);
        cs      = 3'b000;
        write_n = 1'b1;
    endtask

    task automatic rd(input int which, input logic [1:0] addr, output logic [31:0] data);
        address = addr;
        tick(1);
        case (which)
            0:       data = rdata_r;
            1:       data = rdata_l;
            default: data = rdata_f;
        endcase
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(3);
        total++;
        if (rdata_r !== 32'h0) begin
            bad++; $display("FAIL reset_readdata: got %h want %h", rdata_r, 32'h0);
        end
        total++;
        if (irq_r !== 1'b0) begin
            bad++; $display("FAIL reset_irq: got %b want 0", irq_r);
        end
        reset_n = 1'b1;
        tick(10);
        wr(0, ADDR_MASK, 32'hFF);
        total++;
        if (irq_r !== 1'b0) begin
            bad++; $display("FAIL arm_no_spurious_irq: got %b want 0", irq_r);
        end
        rd(0, ADDR_EDGE, val);
        total++;
        if (val !== 32'h0) begin
            bad++; $display("FAIL arm_no_spurious_capture: got %h want %h", val, 32'h0);
        end
        rd(0, ADDR_DATA, val);
        total++;
        if (val !== 32'hFF) begin
            bad++; $display("FAIL reset_data_read: got %h want %h", val, 32'hFF);
        end
    endtask

    task automatic test_rising;
        in_r = 8'h00;
        tick(4);
        wr(0, ADDR_MASK, 32'h01);
        in_r = 8'h81;
        tick(2);
        total++;
        if (irq_r !== 1'b0) begin
            bad++; $display("FAIL rise_irq_early: got %b want 0", irq_r);
        end
        tick(1);
        total++;
        if (irq_r !== 1'b1) begin
            bad++; $display("FAIL rise_irq_latency: got %b want 1", irq_r);
        end
        rd(0, ADDR_EDGE, val);
        total++;
        if (val !== 32'h81) begin
            bad++; $display("FAIL rise_capture: got %h want %h", val, 32'h81);
        end
        wr(0, ADDR_EDGE, 32'h01);
        total++;
        if (irq_r !== 1'b0) begin
            bad++; $display("FAIL rise_irq_cleared: got %b want 0", irq_r);
        end
        rd(0, ADDR_EDGE, val);
        total++;
        if (val !== 32'h80) begin
            bad++; $display("FAIL rise_bit_clear: got %h want %h", val, 32'h80);
        end
        rd(0, ADDR_EDGE, val);
        total++;
        if (val !== 32'h80) begin
            bad++; $display("FAIL read_no_side_effect: got %h want %h", val, 32'h80);
        end
    endtask

    task automatic test_set_wins;
        in_r = 8'h80;
        tick(4);
        in_r = 8'h81;
        tick(4);
        in_r = 8'h80;
        tick(2);
        in_r = 8'h81;
        tick(2);
        total++;
        if (irq_r !== 1'b1) begin
            bad++; $display("FAIL setwin_irq_before: got %b want 1", irq_r);
        end
        wr(0, ADDR_EDGE, 32'h01);
        total++;
        if (irq_r !== 1'b1) begin
            bad++; $display("FAIL setwin_irq_after: got %b want 1", irq_r);
        end
        rd(0, ADDR_EDGE, val);
        total++;
        if (val !== 32'h81) begin
            bad++; $display("FAIL setwin_capture: got %h want %h", val, 32'h81);
        end
    endtask

    task automatic test_level;
        wr(1, ADDR_MASK, 32'h04);
        in_l = 8'h04;
        tick(1);
        total++;
        if (irq_l !== 1'b0) begin
            bad++; $display("FAIL level_irq_early: got %b want 0", irq_l);
        end
        tick(1);
        total++;
        if (irq_l !== 1'b1) begin
            bad++; $display("FAIL level_irq_high: got %b want 1", irq_l);
        end
        in_l = 8'h00;
        tick(2);
        total++;
        if (irq_l !== 1'b0) begin
            bad++; $display("FAIL level_no_latch: got %b want 0", irq_l);
        end
        in_l = 8'h08;
        tick(3);
        total++;
        if (irq_l !== 1'b0) begin
            bad++; $display("FAIL level_unmasked_bit: got %b want 0", irq_l);
        end
        in_l = 8'h04;
        tick(3);
        wr(1, ADDR_MASK, 32'h00);
        total++;
        if (irq_l !== 1'b0) begin
            bad++; $display("FAIL level_mask_off: got %b want 0", irq_l);
        end
    endtask

    task automatic test_falling;
        rd(2, ADDR_EDGE, val);
        total++;
        if (val !== 32'h0) begin
            bad++; $display("FAIL fall_initial: got %h want %h", val, 32'h0);
        end
        wr(2, ADDR_MASK, 32'h0F);
        in_f = 8'hF0;
        tick(2);
        total++;
        if (irq_f !== 1'b0) begin
            bad++; $display("FAIL fall_irq_early: got %b want 0", irq_f);
        end
        tick(1);
        total++;
        if (irq_f !== 1'b1) begin
            bad++; $display("FAIL fall_irq: got %b want 1", irq_f);
        end
        rd(2, ADDR_EDGE, val);
        total++;
        if (val !== 32'h0F) begin
            bad++; $display("FAIL fall_capture: got %h want %h", val, 32'h0F);
        end
        wr(2, ADDR_EDGE, 32'h0);
        total++;
        if (irq_f !== 1'b0) begin
            bad++; $display("FAIL fall_clear_all_irq: got %b want 0", irq_f);
        end
        rd(2, ADDR_EDGE, val);
        total++;
        if (val !== 32'h0) begin
            bad++; $display("FAIL fall_clear_all: got %h want %h", val, 32'h0);
        end
        in_f = 8'hFF;
        tick(4);
        rd(2, ADDR_EDGE, val);
        total++;
        if (val !== 32'h0) begin
            bad++; $display("FAIL fall_ignores_rise: got %h want %h", val, 32'h0);
        end
    endtask

    task automatic test_reads;
        rd(0, ADDR_RSVD, val);
        total++;
        if (val !== 32'h0) begin
            bad++; $display("FAIL read_reserved: got %h want %h", val, 32'h0);
        end
        rd(0, ADDR_DATA, val);
        total++;
        if (val !== 32'h0000_0081) begin
            bad++; $display("FAIL read_data_zext: got %h want %h", val, 32'h81);
        end
        address = ADDR_RSVD;
        #2;
        total++;
        if (rdata_r !== 32'h0000_0081) begin
            bad++; $display("FAIL read_latency_hold: got %h want %h", rdata_r, 32'h81);
        end
        tick(1);
        total++;
        if (rdata_r !== 32'h0) begin
            bad++; $display("FAIL read_latency_update: got %h want %h", rdata_r, 32'h0);
        end
        wr(0, ADDR_DATA, 32'hFF);
        wr(0, ADDR_RSVD, 32'hFF);
        rd(0, ADDR_MASK, val);
        total++;
        if (val !== 32'h01) begin
            bad++; $display("FAIL mask_write_ignored: got %h want %h", val, 32'h01);
        end
    endtask

    task automatic test_reset_mid;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (irq_r !== 1'b0) begin
            bad++; $display("FAIL midreset_irq: got %b want 0", irq_r);
        end
        total++;
        if (rdata_r !== 32'h0) begin
            bad++; $display("FAIL midreset_readdata: got %h want %h", rdata_r, 32'h0);
        end
        tick(2);
        reset_n = 1'b1;
        tick(10);
        wr(0, ADDR_MASK, 32'hFF);
        rd(0, ADDR_EDGE, val);
        total++;
        if (val !== 32'h0) begin
            bad++; $display("FAIL midreset_rearm: got %h want %h", val, 32'h0);
        end
        total++;
        if (irq_r !== 1'b0) begin
            bad++; $display("FAIL midreset_rearm_irq: got %b want 0", irq_r);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs        = 3'b000;
        write_n   = 1'b1;
        writedata = 32'h0;
        in_r      = 8'hFF;
        in_l      = 8'h00;
        in_f      = 8'hFF;
        test_reset();
        test_rising();
        test_set_wins();
        test_level();
        test_falling();
        test_reads();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
